// File: rtl/clk_gate_pkg.sv
// ----------------------------------------------------------------------------
// clk_gate_pkg
// Shared definitions for the clock-gate scheduler:
//   - state_e      : FSM state encoding (SLEEP / WAKE / ACTIVE)
//   - DEF_*        : default bank geometry and idle timeout
//   - idx_width()  : width of a counter/pointer that must hold 0..n-1
// ----------------------------------------------------------------------------
package clk_gate_pkg;

  typedef enum logic [1:0] {
    ST_SLEEP  = 2'd0,
    ST_WAKE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam int DEF_LANES      = 5;
  localparam int DEF_MAX_ACTIVE = 2;
  localparam int DEF_IDLE_LIMIT = 8;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_gate_sched_if.sv
// ----------------------------------------------------------------------------
// clk_gate_sched_if
// Request/enable bundle between the lane requesters and the scheduler.
//   REQ      : per-lane update request (level, held until EN seen)
//   EN       : per-lane write enable / request acknowledge
//   CG_EN    : bank clock-gate enable (0 = bank clock gated)
//   SLEEPING : scheduler is in its SLEEP state
// Modports: master = requester side, slave = scheduler side.
// ----------------------------------------------------------------------------
interface clk_gate_sched_if
  import clk_gate_pkg::*;
#(
  parameter int LANES = DEF_LANES
);

  logic [LANES-1:0] REQ;
  logic [LANES-1:0] EN;
  logic             CG_EN;
  logic             SLEEPING;

  modport master (
    output REQ,
    input  EN,
    input  CG_EN,
    input  SLEEPING
  );

  modport slave (
    input  REQ,
    output EN,
    output CG_EN,
    output SLEEPING
  );

endinterface

// File: rtl/rr_multi_pick.sv
// ----------------------------------------------------------------------------
// rr_multi_pick
// Purely combinational round-robin multi-grant selector.
//   elig     : lanes that may be granted this cycle
//   ptr      : lane the scan starts from (wraps LANES-1 -> 0)
//   grant    : first min(MAX_ACTIVE, popcount(elig)) eligible lanes in scan order
//   next_ptr : lane after the last one granted; ptr when nothing is granted
// ----------------------------------------------------------------------------
module rr_multi_pick
  import clk_gate_pkg::*;
#(
  parameter  int LANES      = DEF_LANES,
  parameter  int MAX_ACTIVE = DEF_MAX_ACTIVE,
  localparam int PTR_W      = idx_width(LANES)
) (
  input  logic [LANES-1:0] elig,
  input  logic [PTR_W-1:0] ptr,
  output logic [LANES-1:0] grant,
  output logic [PTR_W-1:0] next_ptr
);

  // Walk all lanes once starting at ptr, taking eligible lanes until full.
  always_comb begin
    int idx;
    int cnt;
    int last;
    grant = '0;
    idx   = 0;
    cnt   = 0;
    last  = int'(ptr);
    for (int i = 0; i < LANES; i++) begin
      idx = int'(ptr) + i;
      idx = (idx >= LANES) ? idx - LANES : idx;
      if (elig[idx] && (cnt < MAX_ACTIVE)) begin
        grant[idx] = 1'b1;
        cnt        = cnt + 1;
        last       = idx;
      end else begin
        cnt = cnt;
      end
    end
    if (cnt > 0) begin
      next_ptr = (last >= LANES - 1) ? '0 : PTR_W'(last + 1);
    end else begin
      next_ptr = ptr;
    end
  end

endmodule

// File: rtl/clk_gate_sched.sv
// ----------------------------------------------------------------------------
// clk_gate_sched
// Schedules per-lane write enables for a clock-gated register bank and gates
// the bank clock after a run of idle cycles.
//   CLK   : clock, all state changes on the rising edge
//   RST_N : asynchronous active-low reset
//   bus   : slave side of clk_gate_sched_if (REQ in; EN, CG_EN, SLEEPING out)
// FSM: SLEEP (bank gated) -> WAKE (one cycle, clock on, no enables) -> ACTIVE
// (round-robin grants, at most MAX_ACTIVE per cycle) -> SLEEP after
// IDLE_LIMIT idle cycles (IDLE_LIMIT = 0 keeps the bank awake).
// ----------------------------------------------------------------------------
module clk_gate_sched
  import clk_gate_pkg::*;
#(
  parameter  int LANES      = DEF_LANES,
  parameter  int MAX_ACTIVE = DEF_MAX_ACTIVE,
  parameter  int IDLE_LIMIT = DEF_IDLE_LIMIT,
  localparam int PTR_W      = idx_width(LANES),
  localparam int CNT_W      = idx_width(IDLE_LIMIT + 1)
) (
  input logic             CLK,
  input logic             RST_N,
  clk_gate_sched_if.slave bus
);

  localparam logic SLEEP_ENABLED = (IDLE_LIMIT > 0) ? 1'b1 : 1'b0;

  state_e           state_r;
  logic [LANES-1:0] en_r;
  logic             cg_en_r;
  logic [PTR_W-1:0] ptr_r;
  logic [CNT_W-1:0] idle_cnt_r;

  logic [LANES-1:0] eligible_s;
  logic [LANES-1:0] grant_s;
  logic [PTR_W-1:0] next_ptr_s;
  logic             idle_edge_s;
  logic [CNT_W-1:0] idle_cnt_inc_s;
  logic             sleep_now_s;

  // Lanes already enabled this cycle are masked so a held REQ is not granted twice.
  always_comb begin
    eligible_s = bus.REQ & ~en_r;
  end

  rr_multi_pick #(
    .LANES      (LANES),
    .MAX_ACTIVE (MAX_ACTIVE)
  ) u_pick (
    .elig     (eligible_s),
    .ptr      (ptr_r),
    .grant    (grant_s),
    .next_ptr (next_ptr_s)
  );

  // Idle detection: an edge is idle only with no request and no enable in flight.
  // A request arriving on the expiring edge makes the edge non-idle, so it wins.
  always_comb begin
    idle_edge_s = (bus.REQ == '0) && (en_r == '0);
    if (idle_cnt_r < CNT_W'(IDLE_LIMIT)) begin
      idle_cnt_inc_s = idle_cnt_r + CNT_W'(1);
    end else begin
      idle_cnt_inc_s = idle_cnt_r;
    end
    sleep_now_s = SLEEP_ENABLED && (idle_cnt_inc_s == CNT_W'(IDLE_LIMIT));
  end

  // Scheduler FSM with registered EN / CG_EN, round-robin pointer and idle counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= ST_SLEEP;
      en_r       <= '0;
      cg_en_r    <= 1'b0;
      ptr_r      <= '0;
      idle_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_SLEEP: begin
          en_r       <= '0;
          idle_cnt_r <= '0;
          if (bus.REQ != '0) begin
            state_r <= ST_WAKE;
            cg_en_r <= 1'b1;
          end else begin
            cg_en_r <= 1'b0;
          end
        end
        ST_WAKE: begin
          // Clock runs for one cycle before any lane is written.
          state_r    <= ST_ACTIVE;
          cg_en_r    <= 1'b1;
          en_r       <= '0;
          idle_cnt_r <= '0;
        end
        ST_ACTIVE: begin
          en_r <= grant_s;
          if (grant_s != '0) begin
            ptr_r <= next_ptr_s;
          end else begin
            ptr_r <= ptr_r;
          end
          if (idle_edge_s) begin
            if (sleep_now_s) begin
              state_r    <= ST_SLEEP;
              cg_en_r    <= 1'b0;
              idle_cnt_r <= '0;
            end else begin
              idle_cnt_r <= idle_cnt_inc_s;
            end
          end else begin
            idle_cnt_r <= '0;
          end
        end
        default: begin
          state_r    <= ST_SLEEP;
          en_r       <= '0;
          cg_en_r    <= 1'b0;
          ptr_r      <= '0;
          idle_cnt_r <= '0;
        end
      endcase
    end
  end

  // EN and CG_EN come straight from flops; SLEEPING is decoded from the state.
  always_comb begin
    bus.EN       = en_r;
    bus.CG_EN    = cg_en_r;
    bus.SLEEPING = (state_r == ST_SLEEP);
  end

endmodule

// File: doc/clk_gate_sched.md
CLK_GATE_SCHED -- requirements
Module: clk_gate_sched

Interface
REQ-001 Parameter LANES, default 5: number of independently enabled register lanes in the bank.
REQ-002 Parameter MAX_ACTIVE, default 2: maximum lane enables asserted in any one cycle.
REQ-003 Parameter IDLE_LIMIT, default 8: consecutive idle ACTIVE cycles before the bank is gated; 0 disables sleep.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 REQ  input  LANES  per-lane update request; level, held by the requester until it sees its EN bit high.
REQ-007 EN  output  LANES  registered per-lane write enable to the register bank; also acknowledges REQ.
REQ-008 CG_EN  output  1  registered bank clock-gate enable; 0 means the bank clock is gated.
REQ-009 SLEEPING  output  1  high while the FSM is in SLEEP.

Function
REQ-010 The FSM SHALL have exactly three states: SLEEP, WAKE and ACTIVE.
REQ-011 SLEEP: CG_EN=0, EN=0; any REQ bit high at an edge -> WAKE.
REQ-012 WAKE: CG_EN=1, EN=0 for exactly one cycle; then unconditionally -> ACTIVE.
REQ-013 ACTIVE: CG_EN=1; at each edge, eligible lanes are those with REQ=1 and EN=0 (lanes currently enabled are masked, so no double grant).
REQ-014 Selection: scan eligible lanes in round-robin order from pointer PTR, wrapping LANES-1 -> 0; grant the first min(MAX_ACTIVE, eligible count); EN holds the result for one cycle.
REQ-015 After a non-empty grant, PTR = (last lane granted in scan order + 1) mod LANES; with no grant, PTR is unchanged.
REQ-016 Latency: REQ seen at an ACTIVE edge -> EN high after that edge (1 cycle); from SLEEP -> EN high after the third edge.
REQ-017 Idle counter: in ACTIVE, increments each edge where REQ==0 and EN==0; clears on any REQ or EN high; saturates at IDLE_LIMIT.
REQ-018 When IDLE_LIMIT>0 and an idle edge brings the counter to IDLE_LIMIT, the FSM -> SLEEP at that edge, so CG_EN falls and the counter clears.
REQ-019 Simultaneous event: if REQ rises on the edge that would expire the idle counter, the request wins: stay ACTIVE, counter clears, grant is issued normally.
REQ-020 EN SHALL never be nonzero while CG_EN is 0, and popcount(EN) SHALL never exceed MAX_ACTIVE.
REQ-021 SLEEPING = (state == SLEEP); it is combinational from the state register.

Reset
REQ-022 RST_N low SHALL immediately force state=SLEEP, EN=0, CG_EN=0, PTR=0 and idle counter=0, regardless of CLK.
REQ-023 Reset mid-grant discards outstanding grants; requesters holding REQ are serviced through WAKE after release.
REQ-024 The first edge after RST_N rises is evaluated as a normal SLEEP edge.

Structure
REQ-025 Shared package clk_gate_pkg SHALL hold the state encoding (SLEEP/WAKE/ACTIVE) and the default LANES/MAX_ACTIVE/IDLE_LIMIT constants.
REQ-026 Round-robin multi-grant selection SHALL be a sub-module rr_multi_pick (inputs: eligible mask, PTR; outputs: grant mask, next PTR), purely combinational.
REQ-027 All outputs except SLEEPING SHALL be driven directly from flops.

Verification (LANES=5, MAX_ACTIVE=2, IDLE_LIMIT=4)
REQ-028 Reset, REQ=00001 before edge 1, held until EN[0] -> CG_EN=1 after edge 1, EN=00001 after edge 3 only, then REQ drops.
REQ-029 ACTIVE, PTR=0, REQ=11111, each lane drops after its EN -> EN=00011, 01100, 10000 on consecutive cycles; PTR ends at 0.
REQ-030 ACTIVE, PTR=4, REQ=10001 -> EN=10001 in one cycle; PTR becomes 1.
REQ-031 After last EN, REQ=0 for 4 edges -> CG_EN falls after the 4th idle edge, SLEEPING=1; with REQ=00100 at the 4th edge instead -> stays ACTIVE, EN=00100.
REQ-032 RST_N pulsed low mid-cycle while EN=00011 -> EN=0, CG_EN=0, SLEEPING=1 before the next CLK edge; PTR=0 after release.
REQ-033 Random REQ for 10k cycles -> assertions REQ-020 hold, and every held request is granted within ceil(LANES/MAX_ACTIVE)+3 cycles.
